run_ctrl: RTL

Parametrised run-control unit between the board buttons/switches and the single-cycle MIPS core. It replaces the fixed divided `clk_N` with a one-cycle clock-enable `cpu_en` at one of four programmable rates. It adds a debounced `go` button, pause/resume, single-step mode, and syscall-halt handling. An optional executed-cycle counter feeds the seven-segment display mux.

---
 rtl/run_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/run_ctrl.sv
// Run-control unit for the single-cycle MIPS core: debounced go, programmable clock-enable rate,
// pause / single-step / syscall-halt. Define RUN_CTRL_CYCLE_CNT_EN to build the executed-cycle counter.
module run_ctrl #(
    parameter int DIV_W     = 24,
    parameter int DIV0      = 1,
    parameter int DIV1      = 1000,
    parameter int DIV2      = 100000,
    parameter int DIV3      = 10000000,
    parameter int DB_CYCLES = 20000,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             go,
    input  logic             step_mode,
    input  logic [1:0]       hz,
    input  logic             halt,
    output logic             cpu_en,
    output logic             clk_n,
    output logic             running,
    output logic [CNT_W-1:0] cycles
);

    typedef enum logic [1:0] {IDLE, RUN, STEP, HALTED} state_t;

    localparam int DB_CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_CNT_W-1:0] DB_LAST = (DB_CYCLES > 1) ? DB_CNT_W'(DB_CYCLES - 1) : '0;

    // A divisor of 0 or 1 both mean "tick every cycle".
    function automatic logic [DIV_W-1:0] div_last(input int d);
        return (d <= 1) ? '0 : DIV_W'(d - 1);
    endfunction

    localparam logic [DIV_W-1:0] LAST0 = div_last(DIV0);
    localparam logic [DIV_W-1:0] LAST1 = div_last(DIV1);
    localparam logic [DIV_W-1:0] LAST2 = div_last(DIV2);
    localparam logic [DIV_W-1:0] LAST3 = div_last(DIV3);

    logic                go_meta_q, go_meta_d;
    logic                go_s_q, go_s_d;
    logic                deb_q, deb_d;
    logic                deb_prev_q, deb_prev_d;
    logic [DB_CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]          hz_q, hz_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic                clk_n_q, clk_n_d;
    logic                mask_q, mask_d;
    state_t              state_q, state_d;

    logic             go_pulse;
    logic             tick;
    logic             hz_chg;
    logic [DIV_W-1:0] last_sel;

    // Synchroniser and debouncer
    always_comb begin
        go_meta_d  = go;
        go_s_d     = go_meta_q;
        deb_d      = deb_q;
        db_cnt_d   = '0;
        deb_prev_d = deb_q;
        if (go_s_q != deb_q) begin
            if (db_cnt_q == DB_LAST) begin
                deb_d = ~deb_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        go_pulse = deb_q & ~deb_prev_q;
    end

    // Rate divider; a rate change restarts the count and swallows that cycle's tick.
    always_comb begin
        hz_d = hz;
        case (hz_q)
            2'd0:    last_sel = LAST0;
            2'd1:    last_sel = LAST1;
            2'd2:    last_sel = LAST2;
            default: last_sel = LAST3;
        endcase
        hz_chg    = (hz != hz_q);
        tick      = !hz_chg && (div_cnt_q == last_sel);
        div_cnt_d = (hz_chg || tick) ? '0 : div_cnt_q + 1'b1;
        clk_n_d   = clk_n_q ^ tick;
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cpu_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (go_pulse) state_d = step_mode ? STEP : RUN;
            end
            RUN: begin
                if (halt && !mask_q) begin
                    state_d = HALTED;
                end else if (go_pulse) begin
                    state_d = IDLE;
                end else begin
                    cpu_en = tick;
                end
            end
            STEP: begin
                if (tick) begin
                    cpu_en  = 1'b1;
                    state_d = IDLE;
                end
            end
            HALTED: begin
                if (go_pulse) begin
                    state_d = RUN;
                    mask_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // The mask only lets the core step past the syscall once.
        if (cpu_en) mask_d = 1'b0;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            go_meta_q  <= 1'b0;
            go_s_q     <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            db_cnt_q   <= '0;
            hz_q       <= 2'd0;
            div_cnt_q  <= '0;
            clk_n_q    <= 1'b0;
            mask_q     <= 1'b0;
            state_q    <= IDLE;
        end else begin
            go_meta_q  <= go_meta_d;
            go_s_q     <= go_s_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            db_cnt_q   <= db_cnt_d;
            hz_q       <= hz_d;
            div_cnt_q  <= div_cnt_d;
            clk_n_q    <= clk_n_d;
            mask_q     <= mask_d;
            state_q    <= state_d;
        end
    end

    assign clk_n   = clk_n_q;
    assign running = (state_q == RUN);

`ifdef RUN_CTRL_CYCLE_CNT_EN
    logic [CNT_W-1:0] cycles_q, cycles_d;

    always_comb begin
        cycles_d = cpu_en ? cycles_q + 1'b1 : cycles_q;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign cycles = cycles_q;
`else
    assign cycles = '0;
`endif

endmodule
